mem_rr_arbiter: RTL

Round-robin arbiter that shares the single common memory bus (RAM, LEDs, UART, timer, flash decode) between up to eight bus masters, e.g. CPU instruction port, CPU data port and a DMA engine. It accepts the codebase's address/read/write/mask/value/ready/fault handshake on every master port. It grants one master at a time, forwards that master's transaction to the common bus and steers the response back. It can optionally fault transactions that stall on the bus.

---
 rtl/mem_rr_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing the common memory bus between NUM_MASTERS masters
// Optional stall timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_rr_arbiter #(
  parameter int NUM_MASTERS    = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [32*NUM_MASTERS-1:0]   req_address_in,
  input  logic [NUM_MASTERS-1:0]      req_read_in,
  input  logic [NUM_MASTERS-1:0]      req_write_in,
  input  logic [4*NUM_MASTERS-1:0]    req_write_mask_in,
  input  logic [32*NUM_MASTERS-1:0]   req_write_value_in,
  output logic [32*NUM_MASTERS-1:0]   req_read_value_out,
  output logic [NUM_MASTERS-1:0]      req_ready_out,
  output logic [NUM_MASTERS-1:0]      req_fault_out,
  output logic [31:0]                 address_out,
  output logic                        read_out,
  output logic                        write_out,
  output logic [3:0]                  write_mask_out,
  output logic [31:0]                 write_value_out,
  input  logic [31:0]                 read_value_in,
  input  logic                        ready_in,
  input  logic                        fault_in,
  output logic [NUM_MASTERS-1:0]      grant_out
);

  localparam int IW = $clog2(NUM_MASTERS);

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("mem_rr_arbiter: NUM_MASTERS or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          grant_idx_q, grant_idx_d;
  logic [IW-1:0]          last_grant_q, last_grant_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [NUM_MASTERS-1:0] req_pending;
  logic [IW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   g_read, g_write;
  logic                   timeout_hit;

  assign req_pending = req_read_in | req_write_in;
  assign g_read      = req_read_in[grant_idx_q];
  assign g_write     = req_write_in[grant_idx_q];

  // Search downward so the requester nearest after last_grant is the final (winning) assignment.
  always_comb begin
    logic [IW-1:0] idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    idx        = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = IW'((int'(last_grant_q) + k) % NUM_MASTERS);
      if (req_pending[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = idx;
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q, to_cnt_d;

  assign timeout_hit = (state_q == BUSY) && !ready_in && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE)
      to_cnt_d = '0;
    else if (!ready_in)
      to_cnt_d = to_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      to_cnt_q <= '0;
    else
      to_cnt_q <= to_cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d            = state_q;
    grant_idx_d        = grant_idx_q;
    last_grant_d       = last_grant_q;
    grant_d            = grant_out;
    address_out        = '0;
    read_out           = 1'b0;
    write_out          = 1'b0;
    write_mask_out     = '0;
    write_value_out    = '0;
    req_ready_out      = '0;
    req_fault_out      = '0;
    req_read_value_out = '0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = BUSY;
          grant_idx_d = pick_idx;
          grant_d     = NUM_MASTERS'(1) << pick_idx;
        end
      end
      BUSY: begin
        address_out     = req_address_in[32*grant_idx_q +: 32];
        read_out        = g_read;
        write_out       = g_write;
        write_value_out = req_write_value_in[32*grant_idx_q +: 32];
        write_mask_out  = g_write ? req_write_mask_in[4*grant_idx_q +: 4] : 4'b0;
        // An abandoned request ends the grant silently; it still counts toward rotation.
        if (!(g_read || g_write)) begin
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
          grant_d      = '0;
        end else if (ready_in) begin
          req_ready_out[grant_idx_q]                 = 1'b1;
          req_fault_out[grant_idx_q]                 = fault_in;
          req_read_value_out[32*grant_idx_q +: 32]   = read_value_in;
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
          grant_d      = '0;
        end else if (timeout_hit) begin
          req_ready_out[grant_idx_q] = 1'b1;
          req_fault_out[grant_idx_q] = 1'b1;
          state_d      = IDLE;
          last_grant_d = grant_idx_q;
          grant_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_idx_q  <= '0;
      last_grant_q <= IW'(NUM_MASTERS - 1);
      grant_out    <= '0;
    end else begin
      state_q      <= state_d;
      grant_idx_q  <= grant_idx_d;
      last_grant_q <= last_grant_d;
      grant_out    <= grant_d;
    end
  end

endmodule
